// File: rtl/regfile_pkg.sv
// Shared types and constants for the RV32 register file with busy scoreboard.
// Provides address type, special register indices and the x0/trigger test.
package regfile_pkg;

    localparam int A_WIDTH_DEF  = 5;
    localparam int ZERO_REG     = 0;
    localparam int TRIG_REG_DEF = 5;
    localparam int A0_REG_DEF   = 10;

    typedef logic [A_WIDTH_DEF-1:0] reg_addr_t;

    // x0 and the trigger register are never written by writeback,
    // never bypassed and never marked busy.
    function automatic logic is_special(
        input logic [31:0] addr,
        input logic [31:0] trig
    );
        return (addr == 32'(ZERO_REG)) || (addr == trig);
    endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback or flush.
// Ports: clk/rst_n, writeback (we/wa), flush, issue handshake, read-port lookups.
module busy_scoreboard
    import regfile_pkg::*;
#(
    parameter int A_WIDTH  = 5,
    parameter int N_READ   = 2,
    parameter int BYPASS   = 1,
    parameter int TRIG_REG = TRIG_REG_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [A_WIDTH-1:0]        wa,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic [A_WIDTH-1:0]        issue_rd,
    output logic                      issue_ready,
    input  logic [N_READ*A_WIDTH-1:0] rd_addr,
    output logic [N_READ-1:0]         busy_rd
);

    localparam int DEPTH = 1 << A_WIDTH;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             issue_special;

    assign issue_special = is_special(32'(issue_rd), 32'(TRIG_REG));

    // A pending writeback or a flush frees the slot in the same cycle,
    // so the WAW stall only holds when neither is happening.
    assign issue_ready = issue_special
                      || !busy[issue_rd]
                      || (we && wa == issue_rd)
                      || flush;

    always_comb begin
        busy_nxt = busy;
        if (we && wa != '0)
            busy_nxt[wa] = 1'b0;
        if (flush)
            busy_nxt = '0;
        if (issue_valid && issue_ready && !issue_special)
            busy_nxt[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    for (genvar i = 0; i < N_READ; i++) begin : g_rd
        logic [A_WIDTH-1:0] a;
        logic               wb_hit;
        assign a      = rd_addr[i*A_WIDTH +: A_WIDTH];
        assign wb_hit = (BYPASS != 0) && we && (wa == a);
        assign busy_rd[i] = !is_special(32'(a), 32'(TRIG_REG))
                         && busy[a] && !wb_hit;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// RV32 register file: N_READ comb read ports, x0=0, optional WB bypass,
// trigger register, a0 tap, plus a busy scoreboard for RAW/WAW detection.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int A_WIDTH  = 5,
    parameter int D_WIDTH  = 32,
    parameter int N_READ   = 2,
    parameter int BYPASS   = 1,
    parameter int TRIG_REG = TRIG_REG_DEF,
    parameter int A0_REG   = A0_REG_DEF
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      trigger,
    input  logic                      WE3,
    input  logic [A_WIDTH-1:0]        A3,
    input  logic [D_WIDTH-1:0]        WD3,
    input  logic [N_READ*A_WIDTH-1:0] A_RD,
    output logic [N_READ*D_WIDTH-1:0] RD,
    output logic [N_READ-1:0]         busy_rd,
    input  logic                      issue_valid,
    input  logic [A_WIDTH-1:0]        issue_rd,
    output logic                      issue_ready,
    input  logic                      flush,
    output logic [D_WIDTH-1:0]        a0
);

    localparam int DEPTH = 1 << A_WIDTH;
    localparam logic [A_WIDTH-1:0] TRIG_A = A_WIDTH'(TRIG_REG);
    localparam logic [A_WIDTH-1:0] A0_A   = A_WIDTH'(A0_REG);

    logic [D_WIDTH-1:0] regs [DEPTH];
    logic               wb_ok;

    assign wb_ok = WE3 && !is_special(32'(A3), 32'(TRIG_REG));

    // Trigger sample is written after the writeback so it wins on a clash.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            if (wb_ok)
                regs[A3] <= WD3;
            regs[TRIG_A] <= {{(D_WIDTH-1){1'b0}}, trigger};
        end
    end

    for (genvar i = 0; i < N_READ; i++) begin : g_rd
        logic [A_WIDTH-1:0] a;
        logic               hit;
        assign a   = A_RD[i*A_WIDTH +: A_WIDTH];
        assign hit = (BYPASS != 0) && wb_ok && (A3 == a);
        assign RD[i*D_WIDTH +: D_WIDTH] = (a == '0) ? '0
                                        : hit       ? WD3
                                        : regs[a];
    end

    assign a0 = regs[A0_A];

    busy_scoreboard #(
        .A_WIDTH  (A_WIDTH),
        .N_READ   (N_READ),
        .BYPASS   (BYPASS),
        .TRIG_REG (TRIG_REG)
    ) u_sb (
        .clk         (CLK),
        .rst_n       (RST_N),
        .we          (WE3),
        .wa          (A3),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rd_addr     (A_RD),
        .busy_rd     (busy_rd)
    );

endmodule
